ofs_plat_axi_mem_wr_burst_splitter: RTL

- Write-path stage directly downstream of the WLAST-reconstruction stage; consumes its AW/W streams (W with valid last) and its B channel.
- Splits each source INCR write burst longer than MAX_BURST beats into sequential sub-bursts of at most MAX_BURST beats. Regenerates WLAST at each sub-burst boundary.
- Merges the sink's per-sub-burst B responses into exactly one B per source burst.
- AR/R are not handled here.

---
 rtl/ofs_plat_axi_mem_wr_burst_splitter.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ofs_plat_axi_mem_wr_burst_splitter.sv
// ofs_plat_axi_mem_wr_burst_splitter
//
// Purpose:
//   Write-path stage that breaks each source INCR write burst into sub-bursts
//   of at most MAX_BURST beats, regenerates WLAST at every sub-burst boundary
//   and folds the sink's per-sub-burst B responses back into a single B per
//   source burst.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_aw*                 source write address (addr, len, id)
//   s_w*                  source write data (s_wlast ignored, recomputed here)
//   s_b*                  merged write response back to the source
//   m_aw*                 sub-burst write address to the sink
//   m_w*                  write data to the sink with regenerated m_wlast
//   m_b*                  per-sub-burst responses from the sink (m_bid ignored)
//
// Assumptions: the sink returns B in m_aw issue order, and source bursts never
// cross 4 KB, so sub-bursts never do either.

// Small synchronous FIFO used for the sub-burst length queue and the
// outstanding-burst tracker. Callers never push while full.
module ofs_plat_axi_mem_wr_burst_splitter_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module ofs_plat_axi_mem_wr_burst_splitter #(
   parameter int ADDR_W      = 48,
   parameter int DATA_W      = 512,
   parameter int ID_W        = 4,
   parameter int MAX_BURST   = 4,
   parameter int TRACK_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [ADDR_W-1:0]     s_awaddr,
   input  logic [7:0]            s_awlen,
   input  logic [ID_W-1:0]       s_awid,

   input  logic                  s_wvalid,
   output logic                  s_wready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wlast,

   output logic                  s_bvalid,
   input  logic                  s_bready,
   output logic [ID_W-1:0]       s_bid,
   output logic [1:0]            s_bresp,

   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [ADDR_W-1:0]     m_awaddr,
   output logic [7:0]            m_awlen,
   output logic [ID_W-1:0]       m_awid,

   output logic                  m_wvalid,
   input  logic                  m_wready,
   output logic [DATA_W-1:0]     m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   output logic                  m_wlast,

   input  logic                  m_bvalid,
   output logic                  m_bready,
   input  logic [ID_W-1:0]       m_bid,
   input  logic [1:0]            m_bresp
);
   localparam int BYTES   = DATA_W / 8;
   localparam int MB_LOG  = $clog2(MAX_BURST);
   localparam int WLEN_DEPTH = 4;
   localparam logic [8:0] MB9 = 9'(MAX_BURST);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(MAX_BURST * BYTES);

   typedef enum logic {IDLE, ISSUE} state_t;

   // ---------------------------------------------------------------------
   // AW path
   // ---------------------------------------------------------------------
   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ID_W-1:0]   cur_id;
   logic [8:0]        rem;          // beats still to issue, up to 256
   logic [8:0]        sub_beats;    // beats in the sub-burst being offered
   logic [8:0]        nsub;         // sub-bursts the incoming burst will make

   logic              wlen_full;
   logic              wlen_empty;
   logic [7:0]        wlen_head;
   logic              trk_full;
   logic              trk_empty;
   logic [ID_W-1:0]   trk_id;
   logic [8:0]        trk_nsub;

   logic              aw_hs;
   logic              maw_hs;

   assign sub_beats = (rem > MB9) ? MB9 : rem;
   assign nsub      = ({1'b0, s_awlen} >> MB_LOG) + 9'd1;

   // Gating with reset keeps every handshake dead while reset is held, so
   // nothing leaks out on the reset edge itself.
   assign s_awready = !reset && (state == IDLE) && !trk_full && !wlen_full;
   assign m_awvalid = !reset && (state == ISSUE) && !wlen_full;
   assign m_awaddr  = cur_addr;
   assign m_awid    = cur_id;
   assign m_awlen   = 8'(sub_beats - 9'd1);

   assign aw_hs  = s_awvalid && s_awready;
   assign maw_hs = m_awvalid && m_awready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cur_addr <= '0;
         cur_id   <= '0;
         rem      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  cur_addr <= s_awaddr;
                  cur_id   <= s_awid;
                  rem      <= {1'b0, s_awlen} + 9'd1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (maw_hs) begin
                  cur_addr <= cur_addr + ADDR_STEP;
                  rem      <= rem - sub_beats;
                  // Returning to IDLE here means the next s_aw is taken one
                  // cycle after the final m_aw, never in the same cycle.
                  if (rem == sub_beats) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // W path: pass-through with WLAST regenerated from the queued lengths
   // ---------------------------------------------------------------------
   logic [7:0] beat;
   logic       w_hs;
   logic       w_last_hs;

   assign m_wvalid  = !reset && s_wvalid && !wlen_empty;
   assign s_wready  = !reset && m_wready && !wlen_empty;
   assign m_wdata   = s_wdata;
   assign m_wstrb   = s_wstrb;
   assign m_wlast   = (beat == wlen_head);
   assign w_hs      = m_wvalid && m_wready;
   assign w_last_hs = w_hs && m_wlast;

   always_ff @(posedge clk) begin
      if (reset)          beat <= '0;
      else if (w_last_hs) beat <= '0;
      else if (w_hs)      beat <= beat + 8'd1;
   end

   ofs_plat_axi_mem_wr_burst_splitter_fifo #(
      .WIDTH (8),
      .DEPTH (WLEN_DEPTH)
   ) wlen_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (maw_hs),
      .din   (m_awlen),
      .pop   (w_last_hs),
      .dout  (wlen_head),
      .full  (wlen_full),
      .empty (wlen_empty)
   );

   // ---------------------------------------------------------------------
   // B merge: one response per source burst, worst status wins
   // ---------------------------------------------------------------------
   logic [8:0] b_cnt;
   logic [1:0] b_worst;
   logic [1:0] resp_norm;
   logic [1:0] worst_nx;
   logic       mb_hs;
   logic       b_done;

   assign m_bready  = !reset && !s_bvalid;
   assign mb_hs     = m_bvalid && m_bready;
   // EXOKAY only means something for exclusive accesses; fold it into OKAY
   // so that SLVERR/DECERR compare as worse by plain magnitude.
   assign resp_norm = (m_bresp == 2'b01) ? 2'b00 : m_bresp;
   assign worst_nx  = (resp_norm > b_worst) ? resp_norm : b_worst;
   assign b_done    = mb_hs && !trk_empty && ((b_cnt + 9'd1) == trk_nsub);

   always_ff @(posedge clk) begin
      if (reset) begin
         s_bvalid <= 1'b0;
         s_bid    <= '0;
         s_bresp  <= 2'b00;
         b_cnt    <= '0;
         b_worst  <= 2'b00;
      end else begin
         if (s_bvalid && s_bready) s_bvalid <= 1'b0;
         if (b_done) begin
            s_bvalid <= 1'b1;
            s_bid    <= trk_id;
            s_bresp  <= worst_nx;
            b_cnt    <= '0;
            b_worst  <= 2'b00;
         end else if (mb_hs) begin
            b_cnt    <= b_cnt + 9'd1;
            b_worst  <= worst_nx;
         end
      end
   end

   ofs_plat_axi_mem_wr_burst_splitter_fifo #(
      .WIDTH (ID_W + 9),
      .DEPTH (TRACK_DEPTH)
   ) trk_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (aw_hs),
      .din   ({s_awid, nsub}),
      .pop   (b_done),
      .dout  ({trk_id, trk_nsub}),
      .full  (trk_full),
      .empty (trk_empty)
   );

   // A sink response with nothing outstanding means the sink broke ordering.
   assert property (@(posedge clk) disable iff (reset) !(m_bvalid && trk_empty))
      else $error("m_bvalid asserted with no outstanding source burst");

   logic unused_inputs;
   assign unused_inputs = ^{s_wlast, m_bid};

endmodule
